// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, IR field helpers and fetch state encoding
package cpu_pkg;

   localparam logic [2:0] OP_MV  = 3'd0;
   localparam logic [2:0] OP_MVI = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_IMM_FETCH,
      S_IMM_LATCH,
      S_ISSUE,
      S_WAIT_DONE,
      S_HALT
   } fetch_state_t;

   function automatic logic [2:0] ir_opcode(input logic [8:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [2:0] ir_rx(input logic [8:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [2:0] ir_ry(input logic [8:0] ir);
      return ir[2:0];
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with load/increment/hold, wraps modulo 2**ADDR_W
module fetch_pc_reg #(
   parameter int              ADDR_W   = 6,
   parameter logic [ADDR_W-1:0] START_PC = '0
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              load,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (Reset || load) begin
         pc <= START_PC;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch sequencer feeding IR/DIN to the control unit with Run/Done handshake
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 9,
   parameter int START_ADDR = 0,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Start,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRd,
   input  logic [8:0]        MemData,
   output logic [8:0]        IR,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   input  logic              Done,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Halted,
   output logic              Error
);

   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
   localparam int                CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             pc_load, pc_inc, ir_load, din_load;
   logic             cnt_clr, cnt_inc, err_set, err_clr;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .START_PC (START_PC)
   ) u_pc (
      .clk   (clk),
      .Reset (Reset),
      .load  (pc_load),
      .inc   (pc_inc),
      .pc    (PC)
   );

   assign MemAddr = PC;
   assign Busy    = (state != S_IDLE) && (state != S_HALT);
   assign Halted  = (state == S_HALT);

   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      ir_load   = 1'b0;
      din_load  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      MemRd     = 1'b0;
      Run       = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (Start) begin
               state_nxt = S_FETCH;
               pc_load   = 1'b1;
               err_clr   = 1'b1;
            end
         end
         S_FETCH: begin
            MemRd     = 1'b1;
            state_nxt = S_LATCH;
         end
         S_LATCH: begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            case (ir_opcode(MemData))
               OP_MVI:                state_nxt = S_IMM_FETCH;
               OP_MV, OP_ADD, OP_SUB: state_nxt = S_ISSUE;
               default:               state_nxt = S_HALT;
            endcase
         end
         S_IMM_FETCH: begin
            MemRd     = 1'b1;
            state_nxt = S_IMM_LATCH;
         end
         S_IMM_LATCH: begin
            din_load  = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            Run       = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // Done is checked first so a completion on the last allowed cycle still counts
            if (Done) begin
               state_nxt = S_FETCH;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HALT;
               err_set   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         IR    <= '0;
         DIN   <= '0;
         cnt   <= '0;
         Error <= 1'b0;
      end else begin
         if (ir_load) begin
            IR <= MemData;
         end
         if (din_load) begin
            DIN <= DATA_W'(MemData);
         end
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (err_clr) begin
            Error <= 1'b0;
         end else if (err_set) begin
            Error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit against a program-level model
module tb_instr_fetch_unit;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int TO    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          Reset, Start, Done;
   logic [AW-1:0] MemAddr, PC;
   logic          MemRd, Run, Busy, Halted, Error;
   logic [8:0]    MemData, IR;
   logic [DW-1:0] DIN;

   logic [8:0]    rom [DEPTH];

   int checks = 0;
   int errors = 0;
   int m_pc, m_ir, m_din, m_err, m_halted;

   instr_fetch_unit #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .START_ADDR (0),
      .TIMEOUT    (TO)
   ) dut (
      .clk     (clk),
      .Reset   (Reset),
      .Start   (Start),
      .MemAddr (MemAddr),
      .MemRd   (MemRd),
      .MemData (MemData),
      .IR      (IR),
      .DIN     (DIN),
      .Run     (Run),
      .Done    (Done),
      .PC      (PC),
      .Busy    (Busy),
      .Halted  (Halted),
      .Error   (Error)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (MemRd) MemData <= rom[MemAddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [8:0] rand_word(input int op);
      logic [2:0] o;
      o = op[2:0];
      return {o, 6'($urandom)};
   endfunction

   function automatic int rand_plain_op();
      int op;
      op = $urandom_range(0, 2);
      return (op == 1) ? 3 : op;
   endfunction

   task automatic do_reset();
      Reset = 1'b1; Start = 1'b0; Done = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      m_pc = 0; m_ir = 0; m_din = 0; m_err = 0; m_halted = 0;
   endtask

   task automatic start_prog();
      Start = 1'b1; Done = 1'b0;
      tick();
      Start = 1'b0;
      m_pc = 0; m_err = 0; m_halted = 0;
      chk("start_err_clr", 32'(Error), 0);
   endtask

   task automatic check_idle_state(input string tag);
      chk({tag, "_busy"}, 32'(Busy), 0);
      chk({tag, "_halted"}, 32'(Halted), 0);
      chk({tag, "_run"}, 32'(Run), 0);
      chk({tag, "_memrd"}, 32'(MemRd), 0);
      chk({tag, "_pc"}, 32'(PC), 0);
      chk({tag, "_memaddr"}, 32'(MemAddr), 0);
      chk({tag, "_ir"}, 32'(IR), 0);
      chk({tag, "_din"}, 32'(DIN), 0);
      chk({tag, "_err"}, 32'(Error), 0);
   endtask

   task automatic hold_halt();
      for (int i = 0; i < 3; i++) begin
         chk("halt_halted", 32'(Halted), 1);
         chk("halt_busy", 32'(Busy), 0);
         chk("halt_run", 32'(Run), 0);
         chk("halt_memrd", 32'(MemRd), 0);
         chk("halt_pc", 32'(PC), m_pc);
         chk("halt_ir", 32'(IR), m_ir);
         chk("halt_din", 32'(DIN), m_din);
         chk("halt_err", 32'(Error), m_err);
         Done = 1'($urandom);
         tick();
      end
      Done = 1'b0;
   endtask

   // Called at the fetch cycle; d = wait cycles before Done, d >= TO means Done never comes.
   task automatic exec(input int d);
      int w, op;
      w  = int'(rom[m_pc]);
      op = w >> 6;
      chk("fetch_memrd", 32'(MemRd), 1);
      chk("fetch_addr", 32'(MemAddr), m_pc);
      chk("fetch_busy", 32'(Busy), 1);
      chk("fetch_run", 32'(Run), 0);
      Start = 1'($urandom); Done = 1'($urandom);
      tick();
      chk("latch_memrd", 32'(MemRd), 0);
      chk("latch_run", 32'(Run), 0);
      Start = 1'($urandom); Done = 1'($urandom);
      tick();
      Start = 1'b0; Done = 1'b0;
      m_ir = w;
      m_pc = (m_pc + 1) % DEPTH;
      if (op >= 4) begin
         chk("rsvd_halted", 32'(Halted), 1);
         chk("rsvd_ir", 32'(IR), m_ir);
         m_halted = 1;
         hold_halt();
         return;
      end
      if (op == 1) begin
         chk("imm_memrd", 32'(MemRd), 1);
         chk("imm_addr", 32'(MemAddr), m_pc);
         chk("imm_run", 32'(Run), 0);
         Start = 1'($urandom); Done = 1'($urandom);
         tick();
         chk("imml_memrd", 32'(MemRd), 0);
         Start = 1'($urandom); Done = 1'($urandom);
         tick();
         m_din = int'(rom[m_pc]);
         m_pc  = (m_pc + 1) % DEPTH;
      end
      chk("issue_run", 32'(Run), 1);
      chk("issue_ir", 32'(IR), m_ir);
      chk("issue_din", 32'(DIN), m_din);
      chk("issue_pc", 32'(PC), m_pc);
      chk("issue_memrd", 32'(MemRd), 0);
      chk("issue_err", 32'(Error), m_err);
      Start = 1'($urandom); Done = 1'($urandom);
      tick();
      for (int k = 0; k < TO; k++) begin
         chk("wait_run", 32'(Run), 0);
         chk("wait_memrd", 32'(MemRd), 0);
         chk("wait_busy", 32'(Busy), 1);
         chk("wait_halted", 32'(Halted), 0);
         Done  = (k == d);
         Start = 1'($urandom);
         if (k == d) begin
            tick();
            Done = 1'b0; Start = 1'b0;
            return;
         end
         tick();
      end
      Start = 1'b0; Done = 1'b0;
      m_err = 1; m_halted = 1;
      chk("timeout_halted", 32'(Halted), 1);
      chk("timeout_err", 32'(Error), 1);
      hold_halt();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;

      do_reset();
      check_idle_state("reset");
      tick();
      check_idle_state("idle_no_start");

      rom[0] = 9'o012;
      rom[1] = rand_word(2);
      rom[2] = 9'o400;
      start_prog();
      exec(2);
      exec($urandom_range(0, TO - 1));
      exec(0);

      rom[0] = 9'o130;
      rom[1] = 9'h0A5;
      rom[2] = 9'o512;
      start_prog();
      exec(1);
      chk("mvi_din_value", 32'(DIN), 32'h00A5);
      exec(0);

      rom[0] = rand_word(3);
      rom[1] = rand_word(0);
      rom[2] = 9'o777;
      start_prog();
      exec(TO);
      start_prog();
      exec(TO - 1);
      exec(0);
      exec(0);

      rom[0] = 9'o012;
      start_prog();
      tick(); tick(); tick(); tick();
      Reset = 1'b1;
      tick();
      check_idle_state("rst_mid1");
      tick();
      check_idle_state("rst_mid2");
      Reset = 1'b0;
      m_pc = 0; m_ir = 0; m_din = 0; m_err = 0; m_halted = 0;
      tick();
      check_idle_state("rst_after");

      for (int i = 0; i < DEPTH; i++) rom[i] = rand_word(rand_plain_op());
      start_prog();
      for (int i = 0; i < DEPTH + 1; i++) exec($urandom_range(0, 3));

      do_reset();
      rom[DEPTH-1] = rand_word(1);
      start_prog();
      for (int i = 0; i < DEPTH; i++) exec($urandom_range(0, 3));
      chk("wrap_mvi_din", 32'(DIN), 32'(rom[0]));
      chk("wrap_mvi_pc", 32'(m_pc), 1);
      exec(0);

      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         int r;
         r = $urandom_range(0, 9);
         rom[i] = rand_word((r == 9) ? 4 + $urandom_range(0, 3) : r % 4);
      end
      start_prog();
      for (int n = 0; n < 40; n++) begin
         if (m_halted != 0) start_prog();
         exec(($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
